// File: rtl/cardinal_cmp_memsys.sv
// ---------------------------------------------------------------------------
// cardinal_cmp_memsys
//
// Memory and run-control subsystem for the 4-node Cardinal CMP.
//   * Per node N (0..3): private instruction ROM imN (2^IMEM_AW x 32) with a
//     zero-latency combinational fetch, and private data RAM dmN
//     (2^DMEM_AW x 64) with a synchronous write port and a load port.
//   * Completion detection: when every node fetches the all-zero NOP the
//     run controller enters FLUSH, and FLUSH_CYCLES clocks later it raises
//     the sticky program_done flag. cycle_count counts RUN cycles.
//   All buses are big-endian ([0:N-1], bit 0 = MSB).
//
// Ports:
//   clk, reset            system clock; synchronous active-high reset
//   nodeN_pc_in           program counter, word index = pc[22:29]
//   nodeN_inst_out        fetched instruction (combinational)
//   nodeN_addr_in         data address, word index = addr[24:31]
//   nodeN_wdata_in        store data
//   nodeN_rdata_out       load data (0 when not reading)
//   nodeN_memEn           data-memory enable
//   nodeN_memWrEn         write enable, qualified by memEn
//   all_nop               all four fetched instructions are zero
//   program_done          sticky completion flag
//   cycle_count           run cycles since reset release (frozen at NOP)
//
// Optional build macro:
//   CMP_DMEM_REGREAD_EN   registered load data (one-cycle load latency);
//                         undefined gives the combinational load path.
// ---------------------------------------------------------------------------
module cardinal_cmp_memsys #(
    parameter int IMEM_AW      = 8,
    parameter int DMEM_AW      = 8,
    parameter int FLUSH_CYCLES = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:31] node0_pc_in,
    input  logic [0:31] node1_pc_in,
    input  logic [0:31] node2_pc_in,
    input  logic [0:31] node3_pc_in,
    output logic [0:31] node0_inst_out,
    output logic [0:31] node1_inst_out,
    output logic [0:31] node2_inst_out,
    output logic [0:31] node3_inst_out,
    input  logic [0:31] node0_addr_in,
    input  logic [0:31] node1_addr_in,
    input  logic [0:31] node2_addr_in,
    input  logic [0:31] node3_addr_in,
    input  logic [0:63] node0_wdata_in,
    input  logic [0:63] node1_wdata_in,
    input  logic [0:63] node2_wdata_in,
    input  logic [0:63] node3_wdata_in,
    output logic [0:63] node0_rdata_out,
    output logic [0:63] node1_rdata_out,
    output logic [0:63] node2_rdata_out,
    output logic [0:63] node3_rdata_out,
    input  logic        node0_memEn,
    input  logic        node1_memEn,
    input  logic        node2_memEn,
    input  logic        node3_memEn,
    input  logic        node0_memWrEn,
    input  logic        node1_memWrEn,
    input  logic        node2_memWrEn,
    input  logic        node3_memWrEn,
    output logic        all_nop,
    output logic        program_done,
    output logic [0:31] cycle_count
);

    localparam int IMEM_DEPTH = 1 << IMEM_AW;
    localparam int DMEM_DEPTH = 1 << DMEM_AW;
    localparam int FLUSH_W    = $clog2(FLUSH_CYCLES + 1);

    // Storage: one private array per node, word 0 at the lowest address.
    logic [0:31] im0 [0:IMEM_DEPTH-1];
    logic [0:31] im1 [0:IMEM_DEPTH-1];
    logic [0:31] im2 [0:IMEM_DEPTH-1];
    logic [0:31] im3 [0:IMEM_DEPTH-1];
    logic [0:63] dm0 [0:DMEM_DEPTH-1];
    logic [0:63] dm1 [0:DMEM_DEPTH-1];
    logic [0:63] dm2 [0:DMEM_DEPTH-1];
    logic [0:63] dm3 [0:DMEM_DEPTH-1];

    // Word indices; the remaining address bits are don't-care, so accesses
    // wrap modulo the array depth.
    logic [IMEM_AW-1:0] pc_idx0, pc_idx1, pc_idx2, pc_idx3;
    logic [DMEM_AW-1:0] dm_idx0, dm_idx1, dm_idx2, dm_idx3;

    assign pc_idx0 = node0_pc_in[30-IMEM_AW:29];
    assign pc_idx1 = node1_pc_in[30-IMEM_AW:29];
    assign pc_idx2 = node2_pc_in[30-IMEM_AW:29];
    assign pc_idx3 = node3_pc_in[30-IMEM_AW:29];
    assign dm_idx0 = node0_addr_in[32-DMEM_AW:31];
    assign dm_idx1 = node1_addr_in[32-DMEM_AW:31];
    assign dm_idx2 = node2_addr_in[32-DMEM_AW:31];
    assign dm_idx3 = node3_addr_in[32-DMEM_AW:31];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{node0_pc_in[0:29-IMEM_AW], node0_pc_in[30:31],
                                node1_pc_in[0:29-IMEM_AW], node1_pc_in[30:31],
                                node2_pc_in[0:29-IMEM_AW], node2_pc_in[30:31],
                                node3_pc_in[0:29-IMEM_AW], node3_pc_in[30:31],
                                node0_addr_in[0:31-DMEM_AW], node1_addr_in[0:31-DMEM_AW],
                                node2_addr_in[0:31-DMEM_AW], node3_addr_in[0:31-DMEM_AW]};

    // Instruction fetch: zero latency.
    assign node0_inst_out = im0[pc_idx0];
    assign node1_inst_out = im1[pc_idx1];
    assign node2_inst_out = im2[pc_idx2];
    assign node3_inst_out = im3[pc_idx3];

    assign all_nop = (node0_inst_out == 32'h0) && (node1_inst_out == 32'h0) &&
                     (node2_inst_out == 32'h0) && (node3_inst_out == 32'h0);

    // Data write port.
    // NOTE: memory arrays are deliberately outside reset so that program data
    // survives a run-control restart, and so they map onto plain RAM.
    always_ff @(posedge clk) begin
        if (node0_memEn && node0_memWrEn) dm0[dm_idx0] <= node0_wdata_in;
        if (node1_memEn && node1_memWrEn) dm1[dm_idx1] <= node1_wdata_in;
        if (node2_memEn && node2_memWrEn) dm2[dm_idx2] <= node2_wdata_in;
        if (node3_memEn && node3_memWrEn) dm3[dm_idx3] <= node3_wdata_in;
    end

    logic rd0, rd1, rd2, rd3;
    assign rd0 = node0_memEn && !node0_memWrEn;
    assign rd1 = node1_memEn && !node1_memWrEn;
    assign rd2 = node2_memEn && !node2_memWrEn;
    assign rd3 = node3_memEn && !node3_memWrEn;

`ifdef CMP_DMEM_REGREAD_EN
    // Registered load path: the array is sampled before the same-edge write
    // lands, so read-during-write returns the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            node0_rdata_out <= '0;
            node1_rdata_out <= '0;
            node2_rdata_out <= '0;
            node3_rdata_out <= '0;
        end else begin
            node0_rdata_out <= rd0 ? dm0[dm_idx0] : '0;
            node1_rdata_out <= rd1 ? dm1[dm_idx1] : '0;
            node2_rdata_out <= rd2 ? dm2[dm_idx2] : '0;
            node3_rdata_out <= rd3 ? dm3[dm_idx3] : '0;
        end
    end
`else
    assign node0_rdata_out = rd0 ? dm0[dm_idx0] : '0;
    assign node1_rdata_out = rd1 ? dm1[dm_idx1] : '0;
    assign node2_rdata_out = rd2 ? dm2[dm_idx2] : '0;
    assign node3_rdata_out = rd3 ? dm3[dm_idx3] : '0;
`endif

    // Run control.
    typedef enum logic [1:0] {RUN, FLUSH, DONE} run_state_t;

    run_state_t         state, state_nxt;
    logic [31:0]        cycle_q, cycle_nxt;
    logic [FLUSH_W-1:0] flush_cnt, flush_nxt;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            cycle_q   <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            cycle_q   <= cycle_nxt;
            flush_cnt <= flush_nxt;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        cycle_nxt = cycle_q;
        flush_nxt = flush_cnt;
        case (state)
            RUN: begin
                if (all_nop) begin
                    // The cycle in which all_nop is first seen is not counted.
                    state_nxt = (FLUSH_CYCLES <= 1) ? DONE : FLUSH;
                    flush_nxt = FLUSH_W'(1);
                end else begin
                    cycle_nxt = cycle_q + 32'd1;
                end
            end
            FLUSH: begin
                // all_nop is ignored here: once started, the flush completes.
                flush_nxt = flush_cnt + FLUSH_W'(1);
                if (flush_cnt >= FLUSH_W'(FLUSH_CYCLES - 1)) state_nxt = DONE;
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = RUN;
        endcase
    end

    assign program_done = (state == DONE);
    assign cycle_count  = cycle_q;

endmodule

// File: tb/tb_cardinal_cmp_memsys.sv
// ---------------------------------------------------------------------------
// tb_cardinal_cmp_memsys
//
// Self-checking bench for cardinal_cmp_memsys. Keeps plain-array models of
// the instruction ROMs and data RAMs and drives randomized and directed
// traffic; run-control expectations are derived from the run length.
// Honours CMP_DMEM_REGREAD_EN for the load latency.
// ---------------------------------------------------------------------------
module tb_cardinal_cmp_memsys;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:31] pc      [4];
    logic [0:31] inst    [4];
    logic [0:31] addr    [4];
    logic [0:63] wdata   [4];
    logic [0:63] rdata   [4];
    logic        mem_en    [4];
    logic        mem_wr_en [4];
    logic        all_nop;
    logic        program_done;
    logic [0:31] cycle_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_im [4][256];
    logic [63:0] m_dm [4][256];

    always #5 clk = ~clk;

    cardinal_cmp_memsys dut (
        .clk             (clk),
        .reset           (reset),
        .node0_pc_in     (pc[0]),
        .node1_pc_in     (pc[1]),
        .node2_pc_in     (pc[2]),
        .node3_pc_in     (pc[3]),
        .node0_inst_out  (inst[0]),
        .node1_inst_out  (inst[1]),
        .node2_inst_out  (inst[2]),
        .node3_inst_out  (inst[3]),
        .node0_addr_in   (addr[0]),
        .node1_addr_in   (addr[1]),
        .node2_addr_in   (addr[2]),
        .node3_addr_in   (addr[3]),
        .node0_wdata_in  (wdata[0]),
        .node1_wdata_in  (wdata[1]),
        .node2_wdata_in  (wdata[2]),
        .node3_wdata_in  (wdata[3]),
        .node0_rdata_out (rdata[0]),
        .node1_rdata_out (rdata[1]),
        .node2_rdata_out (rdata[2]),
        .node3_rdata_out (rdata[3]),
        .node0_memEn     (mem_en[0]),
        .node1_memEn     (mem_en[1]),
        .node2_memEn     (mem_en[2]),
        .node3_memEn     (mem_en[3]),
        .node0_memWrEn   (mem_wr_en[0]),
        .node1_memWrEn   (mem_wr_en[1]),
        .node2_memWrEn   (mem_wr_en[2]),
        .node3_memWrEn   (mem_wr_en[3]),
        .all_nop         (all_nop),
        .program_done    (program_done),
        .cycle_count     (cycle_count)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int n = 0; n < 4; n++) begin
            mem_en[n]    = 1'b0;
            mem_wr_en[n] = 1'b0;
        end
    endtask

    // Word address with random don't-care bits around the index.
    function automatic logic [31:0] word_addr(input int idx);
        logic [31:0] r;
        r = $urandom;
        return (r & ~32'hFF) | (idx & 255);
    endfunction

    function automatic logic [31:0] pc_of_word(input int idx);
        logic [31:0] r;
        r = $urandom;
        return (r & ~32'h3FC) | ((idx & 255) << 2);
    endfunction

    // Issue a one-cycle load and return the load data at its due time.
    task automatic do_read(input int n, input logic [31:0] a, output logic [63:0] obs);
        mem_en[n]    = 1'b1;
        mem_wr_en[n] = 1'b0;
        addr[n]      = a;
`ifdef CMP_DMEM_REGREAD_EN
        tick();
        obs = rdata[n];
`else
        #1;
        obs = rdata[n];
        tick();
`endif
        mem_en[n] = 1'b0;
    endtask

    // ROM words: word 200 of every node is the NOP, all other words nonzero.
    task automatic load_imem();
        logic [31:0] v;
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 256; i++) begin
                v = (i == 200) ? 32'h0 : ($urandom | 32'h1);
                if (n == 0 && i == 3) v = 32'h12345678;
                m_im[n][i] = v;
                case (n)
                    0: dut.im0[i] = v;
                    1: dut.im1[i] = v;
                    2: dut.im2[i] = v;
                    default: dut.im3[i] = v;
                endcase
            end
        end
    endtask

    // Fill every data word on all nodes through the write ports.
    task automatic fill_dmem();
        for (int i = 0; i < 256; i++) begin
            for (int n = 0; n < 4; n++) begin
                mem_en[n]    = 1'b1;
                mem_wr_en[n] = 1'b1;
                addr[n]      = word_addr(i);
                wdata[n]     = {$urandom, $urandom};
                m_dm[n][i]   = wdata[n];
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        for (int n = 0; n < 4; n++) pc[n] = 32'h0;
        tick();
        tick();
        checks++;
        if (program_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b expected 0", program_done);
        end
        checks++;
        if (cycle_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", cycle_count);
        end
        checks++;
        if (all_nop !== 1'b0) begin
            errors++;
            $display("FAIL reset_all_nop: got %b expected 0", all_nop);
        end
        checks++;
        if (inst[0] !== m_im[0][0]) begin
            errors++;
            $display("FAIL reset_fetch: got %h expected %h", inst[0], m_im[0][0]);
        end
        checks++;
        if (rdata[0] !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 0", rdata[0]);
        end
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        logic [31:0] p;
        logic        exp_nop;
        pc[0] = 32'h0000000C;
        #1;
        checks++;
        if (inst[0] !== 32'h12345678) begin
            errors++;
            $display("FAIL fetch_direct: got %h expected 12345678", inst[0]);
        end
        pc[0] = 32'h0000040C;
        #1;
        checks++;
        if (inst[0] !== 32'h12345678) begin
            errors++;
            $display("FAIL fetch_wrap: got %h expected 12345678", inst[0]);
        end
        tick();
        for (int it = 0; it < 60; it++) begin
            for (int n = 0; n < 4; n++) begin
                p = (it % 10 == 9) ? pc_of_word(200) : $urandom;
                pc[n] = p;
            end
            #1;
            exp_nop = 1'b1;
            for (int n = 0; n < 4; n++) begin
                p = pc[n];
                if (m_im[n][(p >> 2) & 255] != 32'h0) exp_nop = 1'b0;
                checks++;
                if (inst[n] !== m_im[n][(p >> 2) & 255]) begin
                    errors++;
                    $display("FAIL fetch_rand node%0d pc=%h: got %h expected %h",
                             n, p, inst[n], m_im[n][(p >> 2) & 255]);
                end
            end
            checks++;
            if (all_nop !== exp_nop) begin
                errors++;
                $display("FAIL all_nop_rand: got %b expected %b", all_nop, exp_nop);
            end
            tick();
        end
        for (int n = 0; n < 4; n++) pc[n] = 32'h0;
    endtask

    task automatic test_write_read();
        logic [63:0] obs;
        idle();
        mem_en[2]    = 1'b1;
        mem_wr_en[2] = 1'b1;
        addr[2]      = 32'h00000010;
        wdata[2]     = 64'hDEADBEEFCAFEF00D;
        tick();
        m_dm[2][16] = 64'hDEADBEEFCAFEF00D;
        idle();
        do_read(2, 32'h00000110, obs);
        checks++;
        if (obs !== 64'hDEADBEEFCAFEF00D) begin
            errors++;
            $display("FAIL write_read node2: got %h expected deadbeefcafef00d", obs);
        end
        for (int n = 0; n < 4; n++) begin
            if (n != 2) begin
                do_read(n, 32'h00000010, obs);
                checks++;
                if (obs !== m_dm[n][16]) begin
                    errors++;
                    $display("FAIL isolation node%0d: got %h expected %h", n, obs, m_dm[n][16]);
                end
            end
        end
    endtask

    task automatic test_write_gating();
        logic [63:0] obs;
        idle();
        mem_en[1]    = 1'b0;
        mem_wr_en[1] = 1'b1;
        addr[1]      = 32'h00000005;
        wdata[1]     = 64'hFFFFFFFFFFFFFFFF;
        tick();
        checks++;
        if (rdata[1] !== 64'h0) begin
            errors++;
            $display("FAIL gated_rdata: got %h expected 0", rdata[1]);
        end
        idle();
        do_read(1, 32'h00000005, obs);
        checks++;
        if (obs !== m_dm[1][5]) begin
            errors++;
            $display("FAIL gated_write: got %h expected %h", obs, m_dm[1][5]);
        end
    endtask

    task automatic test_parallel_write();
        logic [63:0] obs;
        for (int n = 0; n < 4; n++) begin
            mem_en[n]    = 1'b1;
            mem_wr_en[n] = 1'b1;
            addr[n]      = word_addr(7);
            wdata[n]     = {$urandom, 28'h0, 4'(n)};
        end
        tick();
        for (int n = 0; n < 4; n++) m_dm[n][7] = wdata[n];
        idle();
        for (int n = 0; n < 4; n++) begin
            do_read(n, 32'h7, obs);
            checks++;
            if (obs !== m_dm[n][7]) begin
                errors++;
                $display("FAIL parallel node%0d: got %h expected %h", n, obs, m_dm[n][7]);
            end
        end
    endtask

    task automatic test_random_traffic();
        logic [63:0] exp_rd [4];
        logic [31:0] a;
        for (int it = 0; it < 300; it++) begin
            for (int n = 0; n < 4; n++) begin
                mem_en[n]    = ($urandom_range(0, 9) < 8);
                mem_wr_en[n] = ($urandom_range(0, 2) == 0);
                addr[n]      = word_addr($urandom_range(0, 15));
                wdata[n]     = {$urandom, $urandom};
                a            = addr[n];
                exp_rd[n]    = (mem_en[n] && !mem_wr_en[n]) ? m_dm[n][a & 255] : 64'h0;
            end
`ifndef CMP_DMEM_REGREAD_EN
            #1;
            for (int n = 0; n < 4; n++) begin
                checks++;
                if (rdata[n] !== exp_rd[n]) begin
                    errors++;
                    $display("FAIL traffic node%0d it=%0d: got %h expected %h",
                             n, it, rdata[n], exp_rd[n]);
                end
            end
`endif
            @(posedge clk);
            for (int n = 0; n < 4; n++) begin
                a = addr[n];
                if (mem_en[n] && mem_wr_en[n]) m_dm[n][a & 255] = wdata[n];
            end
            #1;
`ifdef CMP_DMEM_REGREAD_EN
            for (int n = 0; n < 4; n++) begin
                checks++;
                if (rdata[n] !== exp_rd[n]) begin
                    errors++;
                    $display("FAIL traffic node%0d it=%0d: got %h expected %h",
                             n, it, rdata[n], exp_rd[n]);
                end
            end
`endif
        end
        idle();
        tick();
    endtask

    task automatic test_read_latency();
        idle();
        mem_en[0]    = 1'b1;
        mem_wr_en[0] = 1'b1;
        addr[0]      = 32'h9;
        wdata[0]     = 64'h1;
        tick();
        m_dm[0][9] = 64'h1;
        mem_wr_en[0] = 1'b0;
        #1;
`ifdef CMP_DMEM_REGREAD_EN
        checks++;
        if (rdata[0] !== 64'h0) begin
            errors++;
            $display("FAIL latency_issue: got %h expected 0", rdata[0]);
        end
        tick();
`endif
        checks++;
        if (rdata[0] !== 64'h1) begin
            errors++;
            $display("FAIL latency_data: got %h expected 1", rdata[0]);
        end
        idle();
        tick();
    endtask

    task automatic test_run_control();
        int          run_len;
        logic [63:0] obs;
        logic [31:0] p;
        for (int trial = 0; trial < 3; trial++) begin
            run_len = (trial == 0) ? 40 : $urandom_range(3, 60);
            idle();
            for (int n = 0; n < 4; n++) pc[n] = 32'h0;
            reset = 1'b1;
            tick();
            reset = 1'b0;
            for (int c = 1; c <= run_len; c++) begin
                tick();
                checks++;
                if (cycle_count !== 32'(c) || program_done !== 1'b0) begin
                    errors++;
                    $display("FAIL run_count: got %0d/%b expected %0d/0",
                             cycle_count, program_done, c);
                end
            end
            for (int n = 0; n < 4; n++) pc[n] = pc_of_word(200);
            #1;
            checks++;
            if (all_nop !== 1'b1) begin
                errors++;
                $display("FAIL nop_detect: got %b expected 1", all_nop);
            end
            for (int k = 1; k <= 8; k++) begin
                tick();
                // Later trials drop the NOP mid-flush; the flush must still finish.
                if (trial > 0 && k == 2) pc[$urandom_range(0, 3)] = pc_of_word(1);
                checks++;
                if (program_done !== (k >= 5)) begin
                    errors++;
                    $display("FAIL done_timing k=%0d: got %b expected %b",
                             k, program_done, (k >= 5));
                end
                checks++;
                if (cycle_count !== 32'(run_len)) begin
                    errors++;
                    $display("FAIL count_freeze: got %0d expected %0d", cycle_count, run_len);
                end
            end
        end
        // A one-cycle reset clears run control but keeps memory contents.
        for (int n = 0; n < 4; n++) pc[n] = 32'h0;
        reset = 1'b1;
        tick();
        checks++;
        if (program_done !== 1'b0 || cycle_count !== 32'h0) begin
            errors++;
            $display("FAIL rerun_reset: got %b/%0d expected 0/0", program_done, cycle_count);
        end
        reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            do_read(n, 32'h10, obs);
            checks++;
            if (obs !== m_dm[n][16]) begin
                errors++;
                $display("FAIL preserve_dm node%0d: got %h expected %h", n, obs, m_dm[n][16]);
            end
            p = pc_of_word(3);
            pc[n] = p;
            #1;
            checks++;
            if (inst[n] !== m_im[n][3]) begin
                errors++;
                $display("FAIL preserve_im node%0d: got %h expected %h", n, inst[n], m_im[n][3]);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int n = 0; n < 4; n++) begin
            pc[n]    = 32'h0;
            addr[n]  = 32'h0;
            wdata[n] = 64'h0;
        end
        idle();
        load_imem();
        test_reset();
        fill_dmem();
        test_fetch();
        test_write_read();
        test_write_gating();
        test_parallel_write();
        test_random_traffic();
        test_read_latency();
        test_run_control();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
